// File: rtl/pipe_wb_regfile_fpu.sv
// Write-back stage of the FPU-extended MIPS pipeline: selects the result, commits it
// to the integer or FP register file, and serves bypassed ID-stage reads plus debug counters.
module pipe_wb_regfile_fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic        wwreg,
  input  logic        wm2reg,
  input  logic [31:0] wmo,
  input  logic [31:0] walu,
  input  logic [4:0]  wrn,
  input  logic        wwfpr,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  input  logic [4:0]  fs,
  input  logic [4:0]  ft,
  output logic [31:0] qa,
  output logic [31:0] qb,
  output logic [31:0] fqs,
  output logic [31:0] fqt,
  output logic [31:0] wdi,
  output logic [31:0] gpr_wcnt,
  output logic [31:0] fpr_wcnt,
  output logic        wb_conflict
);

  // GPR 0 is hardwired to zero, so only entries 1..31 exist as storage.
  logic [31:0] gpr [1:31];
  logic [31:0] fpr [0:31];
  logic        gpr_we;
  logic        fpr_we;

  assign wdi = wm2reg ? wmo : walu;

  // FP writes win when both enables are set; an integer write to r0 is dropped.
  assign fpr_we = wwfpr;
  assign gpr_we = wwreg && !wwfpr && (wrn != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) gpr[i] <= '0;
      for (int i = 0; i < 32; i++) fpr[i] <= '0;
      gpr_wcnt    <= '0;
      fpr_wcnt    <= '0;
      wb_conflict <= 1'b0;
    end else begin
      if (fpr_we) begin
        fpr[wrn] <= wdi;
        fpr_wcnt <= fpr_wcnt + 32'd1;
      end
      if (gpr_we) begin
        gpr[wrn] <= wdi;
        gpr_wcnt <= gpr_wcnt + 32'd1;
      end
      if (wwreg && wwfpr) wb_conflict <= 1'b1;
    end
  end

  // Same-cycle write-through so ID sees a value in the cycle it is committed.
  assign qa  = (rna == 5'd0) ? 32'd0 : (gpr_we && rna == wrn) ? wdi : gpr[rna];
  assign qb  = (rnb == 5'd0) ? 32'd0 : (gpr_we && rnb == wrn) ? wdi : gpr[rnb];
  assign fqs = (fpr_we && fs == wrn) ? wdi : fpr[fs];
  assign fqt = (fpr_we && ft == wrn) ? wdi : fpr[ft];

endmodule

// File: tb/tb_pipe_wb_regfile_fpu.sv
// Self-checking bench for pipe_wb_regfile_fpu: table vectors, corner sequences and
// randomized traffic compared against an array-based model of the register files.
module tb_pipe_wb_regfile_fpu;

  logic        clk;
  logic        rst;
  logic        wwreg;
  logic        wm2reg;
  logic [31:0] wmo;
  logic [31:0] walu;
  logic [4:0]  wrn;
  logic        wwfpr;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic [4:0]  fs;
  logic [4:0]  ft;
  logic [31:0] qa;
  logic [31:0] qb;
  logic [31:0] fqs;
  logic [31:0] fqt;
  logic [31:0] wdi;
  logic [31:0] gpr_wcnt;
  logic [31:0] fpr_wcnt;
  logic        wb_conflict;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] gm [32];
  logic [31:0] fm [32];
  logic [31:0] gcnt;
  logic [31:0] fcnt;
  logic        conf;

  typedef struct {
    logic        wr;
    logic        m2r;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
    logic        fw;
    logic [4:0]  ra;
    logic [4:0]  fsa;
    logic [31:0] eqa;
    logic [31:0] efqs;
  } vec_t;

  vec_t vecs [6];

  pipe_wb_regfile_fpu dut (
    .clk(clk), .rst(rst), .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu),
    .wrn(wrn), .wwfpr(wwfpr), .rna(rna), .rnb(rnb), .fs(fs), .ft(ft),
    .qa(qa), .qb(qb), .fqs(fqs), .fqt(fqt), .wdi(wdi),
    .gpr_wcnt(gpr_wcnt), .fpr_wcnt(fpr_wcnt), .wb_conflict(wb_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      gm[i] = '0;
      fm[i] = '0;
    end
    gcnt = '0;
    fcnt = '0;
    conf = 1'b0;
  endtask

  function automatic logic [31:0] expWdi();
    return wm2reg ? wmo : walu;
  endfunction

  function automatic logic [31:0] expInt(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wwreg && !wwfpr && wrn != 5'd0 && a == wrn) return expWdi();
    return gm[a];
  endfunction

  function automatic logic [31:0] expFp(input logic [4:0] a);
    if (wwfpr && a == wrn) return expWdi();
    return fm[a];
  endfunction

  // Drive one cycle's bundle away from the rising edge, then let it settle.
  task automatic applyStimulus(input logic wr, input logic m2r, input logic [31:0] mo,
                               input logic [31:0] alu, input logic [4:0] rn, input logic fw,
                               input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] s, input logic [4:0] t);
    @(negedge clk);
    wwreg = wr; wm2reg = m2r; wmo = mo; walu = alu; wrn = rn; wwfpr = fw;
    rna = a; rnb = b; fs = s; ft = t;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".wdi"}, wdi, expWdi());
    check({tag, ".qa"}, qa, expInt(rna));
    check({tag, ".qb"}, qb, expInt(rnb));
    check({tag, ".fqs"}, fqs, expFp(fs));
    check({tag, ".fqt"}, fqt, expFp(ft));
    check({tag, ".gpr_wcnt"}, gpr_wcnt, gcnt);
    check({tag, ".fpr_wcnt"}, fpr_wcnt, fcnt);
    check({tag, ".wb_conflict"}, {31'd0, wb_conflict}, {31'd0, conf});
  endtask

  // Advance through the rising edge and apply the commit rules to the model.
  task automatic stepClock();
    logic [31:0] d;
    @(posedge clk);
    d = expWdi();
    if (wwfpr) begin
      fm[wrn] = d;
      fcnt = fcnt + 1;
    end else if (wwreg && wrn != 5'd0) begin
      gm[wrn] = d;
      gcnt = gcnt + 1;
    end
    if (wwreg && wwfpr) conf = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0, 32'h1234_5678, 5'd5, 1'b0, 5'd5, 5'd0, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h3F80_0000, 5'd0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h3F80_0000};
    vecs[4] = '{1'b1, 1'b0, 32'h0, 32'hA5A5_A5A5, 5'd7, 1'b1, 5'd7, 5'd7, 32'h0, 32'hA5A5_A5A5};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h0, 32'hA5A5_A5A5};

    wwreg = 0; wm2reg = 0; wmo = 0; walu = 0; wrn = 0; wwfpr = 0;
    rna = 0; rnb = 0; fs = 0; ft = 0;
    rst = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Reset contents on every read port
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 5'(i), 5'(31 - i), 5'(i), 5'(31 - i));
      checkOutput("reset");
      stepClock();
    end

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].m2r, vecs[i].mo, vecs[i].alu, vecs[i].rn, vecs[i].fw,
                    vecs[i].ra, vecs[i].ra, vecs[i].fsa, vecs[i].fsa);
      checkOutput($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_qa", i), qa, vecs[i].eqa);
      check($sformatf("vec%0d.tbl_fqs", i), fqs, vecs[i].efqs);
      stepClock();
    end
    check("after_vec.gpr_wcnt", gpr_wcnt, 32'd1);
    check("after_vec.fpr_wcnt", fpr_wcnt, 32'd2);

    // Conflict flag must hold across idle cycles
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 5'd7, 5'd5, 5'd7, 5'd0);
      check("conflict_hold", {31'd0, wb_conflict}, 32'd1);
      stepClock();
    end

    // Preload the FP counter near wrap, then two FP writes
    @(negedge clk);
    force dut.fpr_wcnt = 32'hFFFF_FFFE;
    @(posedge clk);
    #1 release dut.fpr_wcnt;
    fcnt = 32'hFFFF_FFFE;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h1111_0001, 5'd3, 1'b1, 5'd0, 5'd0, 5'd3, 5'd4);
    checkOutput("wrap0");
    stepClock();
    applyStimulus(1'b0, 1'b1, 32'h2222_0002, 32'h0, 5'd4, 1'b1, 5'd0, 5'd0, 5'd3, 5'd4);
    checkOutput("wrap1");
    check("wrap1.fpr_wcnt_max", fpr_wcnt, 32'hFFFF_FFFF);
    stepClock();
    #1 check("wrap2.fpr_wcnt_zero", fpr_wcnt, 32'h0);

    // Burst of alternating writes with an asynchronous reset mid-cycle
    for (int k = 0; k < 4; k++) begin
      applyStimulus(!k[0], 1'b0, 32'h0, 32'hC0DE_0000 + 32'(k), 5'(10 + k), k[0],
                    5'd10, 5'd12, 5'd11, 5'd3);
      checkOutput($sformatf("burst%0d", k));
      if (k < 3) stepClock();
    end
    #1 rst = 1'b1;
    #1;
    check("async_rst.qa", qa, 32'h0);
    check("async_rst.qb", qb, 32'h0);
    check("async_rst.fqs", fqs, 32'h0);
    check("async_rst.fqt", fqt, 32'h0);
    check("async_rst.gpr_wcnt", gpr_wcnt, 32'h0);
    check("async_rst.fpr_wcnt", fpr_wcnt, 32'h0);
    check("async_rst.wb_conflict", {31'd0, wb_conflict}, 32'd0);
    modelReset();
    @(posedge clk);
    #2 rst = 1'b0;
    fs = 5'd13;
    #1 checkOutput("post_rst");
    stepClock();
    #1 check("post_rst.fpr_wcnt", fpr_wcnt, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rn;
      rn = 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, rn,
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0) ? rn : 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)),
                    ($urandom_range(0, 2) == 0) ? rn : 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)));
      checkOutput("rand");
      stepClock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_wb_regfile_fpu.md
# pipe_wb_regfile_fpu

Write-back end of the MEM/WB pipeline interface for the FPU-extended MIPS pipeline. Consumes the registered write-back bundle (write enables, memory/ALU results, destination number, FP-write flag), selects the result, and commits it into either the 32×32 integer register file or the 32×32 floating-point register file. Provides two integer and two FP combinational read ports for the ID stage, with same-cycle write-through bypass. Also keeps retire counters and a sticky conflict flag for debug.

## Interface
Parameters: none (widths fixed: 32-bit data, 5-bit register numbers, 32 entries per file).

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wwreg  in  1  integer register write enable from MEM/WB
- wm2reg  in  1  result select: 1 = memory data, 0 = ALU result
- wmo  in  32  memory read data from MEM/WB
- walu  in  32  ALU/FPU result from MEM/WB
- wrn  in  5  destination register number
- wwfpr  in  1  FP register write enable from MEM/WB
- rna, rnb  in  5 each  integer read addresses
- fs, ft  in  5 each  FP read addresses
- qa, qb  out  32 each  integer read data
- fqs, fqt  out  32 each  FP read data
- wdi  out  32  selected write-back data (for forwarding into EX)
- gpr_wcnt  out  32  count of committed integer writes
- fpr_wcnt  out  32  count of committed FP writes
- wb_conflict  out  1  sticky: wwreg and wwfpr seen high together

## Operation
- wdi = wm2reg ? wmo : walu, purely combinational.
- Commit decode per cycle:
  - wwfpr=1: FPR[wrn] <= wdi (FPR 0 is a normal writable register); fpr_wcnt += 1.
  - else wwreg=1 and wrn≠0: GPR[wrn] <= wdi; gpr_wcnt += 1.
  - wwreg=1, wrn=0, wwfpr=0: no write, no count.
  - wwreg=wwfpr=1: FP write only (FP has priority), fpr_wcnt increments, gpr_wcnt does not; wb_conflict <= 1 and stays 1 until rst.
- GPR 0 reads always 0, including under bypass.
- Read bypass: integer port returns wdi when wwreg=1, wwfpr=0, wrn≠0, and address==wrn; FP port returns wdi when wwfpr=1 and address==wrn; otherwise array contents.
- Counters are 32-bit, wrap from 0xFFFF_FFFF to 0 with no flag.

## Timing
- Reads and wdi: zero-latency combinational from inputs and array state.
- Write: visible in array one cycle after the edge at which it commits; visible on read ports in the same cycle via bypass, so a read in the commit cycle and in every later cycle returns the new value.
- Counters and wb_conflict update on the same edge as the write.
- Reset (asynchronous assert, any time, including mid-stream): all 31 GPRs, all 32 FPRs, gpr_wcnt, fpr_wcnt, wb_conflict go to 0 immediately; qa/qb/fqs/fqt then read 0 unless bypass is active. Inputs present in the cycle of reset deassertion commit normally at the first edge with rst low.
- No stall or handshake: every cycle with an enable set commits exactly one write.

## Test plan
- Reset then read all 32 addresses on every port -> all 0; counters 0; wb_conflict 0.
- wwreg=1, wm2reg=0, walu=0x1234_5678, wrn=5, rna=5 in the same cycle -> qa=0x1234_5678 in that cycle and after the edge; gpr_wcnt=1.
- wwreg=1, wm2reg=1, wmo=0xDEAD_BEEF, wrn=0 -> no write, qa(rna=0)=0, gpr_wcnt unchanged.
- wwfpr=1, walu=0x3F80_0000, wrn=0, fs=0 -> fqs=0x3F80_0000; GPR0 still 0; fpr_wcnt=1.
- wwreg=wwfpr=1, wrn=7, walu=0xA5A5_A5A5 -> FPR7=0xA5A5_A5A5, GPR7 unchanged, wb_conflict=1 and held 1 over 10 idle cycles until rst.
- Load fpr_wcnt to 0xFFFF_FFFE by forced writes, two more FP writes -> 0xFFFF_FFFF then 0; assert rst mid-burst -> all state 0 immediately, without waiting for a clock edge.
